alu_bitcnt_seq: RTL and testbench

ALU_BITCNT_SEQ -- requirements
Module: alu_bitcnt_seq

---
 rtl/alu_bitcnt_seq_pkg.sv | 12 +
 rtl/alu_bitcnt_seq_bitcnt.sv | 21 ++
 rtl/alu_bitcnt_seq.sv | 114 +++++++++++
 tb/tb_alu_bitcnt_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_bitcnt_seq_pkg.sv
// Shared definitions for the burst bit-count unit: FSM encodings and default burst size.
package alu_bitcnt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAX_WORDS_DEF = 16;

endpackage

// File: rtl/alu_bitcnt_seq_bitcnt.sv
// Combinational 32-bit popcount: per-nibble partial counts summed into a 6-bit total.
module alu_bitcnt (
  input  logic [31:0] din,
  output logic [5:0]  cnt
);

  logic [2:0] nib_cnt [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    assign nib_cnt[gi] = {2'b00, din[4*gi]}   + {2'b00, din[4*gi+1]}
                       + {2'b00, din[4*gi+2]} + {2'b00, din[4*gi+3]};
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, nib_cnt[i]};
    end
  end

endmodule

// File: rtl/alu_bitcnt_seq.sv
// Burst bit counter: accepts a length/mode command, accumulates the popcount of each
// data word (ones or zeros) and holds the total until the consumer takes it.
module alu_bitcnt_seq
  import alu_bitcnt_seq_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF,
  parameter int CW        = $clog2(MAX_WORDS * 32) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [4:0]    cmd_len,
  input  logic          cmd_zeros,
  input  logic          data_valid,
  output logic          data_ready,
  input  logic [31:0]   data_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_count,
  output logic          res_err
);

  state_t        state_reg;
  logic [CW-1:0] acc_reg;
  logic [4:0]    rem_reg;
  logic          mode_reg;
  logic          cmd_ready_reg;
  logic          data_ready_reg;
  logic          res_valid_reg;
  logic [CW-1:0] res_count_reg;
  logic          res_err_reg;

  logic [5:0]    pc_cnt;
  logic [CW-1:0] acc_next;
  logic          len_too_big;

  // Zeros mode inverts the word so the same popcount block counts cleared bits.
  alu_bitcnt u_bitcnt (
    .din (data_in ^ {32{mode_reg}}),
    .cnt (pc_cnt)
  );

  assign acc_next    = acc_reg + CW'(pc_cnt);
  assign len_too_big = int'(cmd_len) > MAX_WORDS;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      acc_reg        <= '0;
      rem_reg        <= '0;
      mode_reg       <= 1'b0;
      cmd_ready_reg  <= 1'b1;
      data_ready_reg <= 1'b0;
      res_valid_reg  <= 1'b0;
      res_count_reg  <= '0;
      res_err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid && cmd_ready_reg) begin
            cmd_ready_reg <= 1'b0;
            mode_reg      <= cmd_zeros;
            acc_reg       <= '0;
            if (cmd_len == 5'd0 || len_too_big) begin
              // Empty or oversized bursts finish at once without touching data.
              state_reg     <= DONE;
              res_valid_reg <= 1'b1;
              res_count_reg <= '0;
              res_err_reg   <= len_too_big;
            end else begin
              state_reg      <= ACCUM;
              rem_reg        <= cmd_len;
              data_ready_reg <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (data_valid && data_ready_reg) begin
            acc_reg <= acc_next;
            rem_reg <= rem_reg - 5'd1;
            if (rem_reg == 5'd1) begin
              state_reg      <= DONE;
              data_ready_reg <= 1'b0;
              res_valid_reg  <= 1'b1;
              res_count_reg  <= acc_next;
              res_err_reg    <= 1'b0;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state_reg     <= IDLE;
            res_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg      <= IDLE;
          cmd_ready_reg  <= 1'b1;
          data_ready_reg <= 1'b0;
          res_valid_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_reg;
  assign data_ready = data_ready_reg;
  assign res_valid  = res_valid_reg;
  assign res_count  = res_count_reg;
  assign res_err    = res_err_reg;

endmodule

// File: tb/tb_alu_bitcnt_seq.sv
// Directed bench for alu_bitcnt_seq: vector table of bursts plus gap, hold and reset sequences.
module tb_alu_bitcnt_seq;

  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [4:0]    cmd_len;
  logic          cmd_zeros;
  logic          data_valid;
  logic          data_ready;
  logic [31:0]   data_in;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_count;
  logic          res_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_bitcnt_seq #(.MAX_WORDS(16), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_zeros  (cmd_zeros),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_in    (data_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_count  (res_count),
    .res_err    (res_err)
  );

  typedef struct {
    logic [4:0]  len;
    logic        zeros;
    logic [31:0] w [4];
    logic [9:0]  exp_count;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [4:0] len, input logic z);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_zeros = z;
    while (!cmd_ready && t < 100) begin
      tick();
      t++;
    end
    chk("cmd_accept_timeout", 32'(t < 100), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input logic last);
    int t = 0;
    data_valid = 1'b0;
    repeat (gap) tick();
    data_valid = 1'b1;
    data_in    = w;
    while (!data_ready && t < 100) begin
      tick();
      t++;
    end
    chk("data_accept_timeout", 32'(t < 100), 32'd1);
    tick();
    data_valid = 1'b0;
    if (last) chk("last_word_latency", 32'(res_valid), 32'd1);
  endtask

  task automatic get_result(input int hold, input logic [9:0] exp_count, input logic exp_err);
    int t = 0;
    while (!res_valid && t < 100) begin
      tick();
      t++;
    end
    chk("result_timeout", 32'(t < 100), 32'd1);
    chk("res_count", 32'(res_count), 32'(exp_count));
    chk("res_err", 32'(res_err), 32'(exp_err));
    chk("cmd_ready_in_done", 32'(cmd_ready), 32'd0);
    repeat (hold) begin
      tick();
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_count", 32'(res_count), 32'(exp_count));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_cleared", 32'(res_valid), 32'd0);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{len: 5'd3,  zeros: 1'b0, w: '{32'hFFFF_FFFF, 32'h0000_000F, 32'h8000_0001, 32'h0}, exp_count: 10'd38, exp_err: 1'b0};
    vecs[1] = '{len: 5'd2,  zeros: 1'b1, w: '{32'h0000_0000, 32'hFFFF_0000, 32'h0, 32'h0}, exp_count: 10'd48, exp_err: 1'b0};
    vecs[2] = '{len: 5'd0,  zeros: 1'b0, w: '{32'h0, 32'h0, 32'h0, 32'h0}, exp_count: 10'd0, exp_err: 1'b0};
    vecs[3] = '{len: 5'd17, zeros: 1'b0, w: '{32'h0, 32'h0, 32'h0, 32'h0}, exp_count: 10'd0, exp_err: 1'b1};
    vecs[4] = '{len: 5'd1,  zeros: 1'b0, w: '{32'h1234_5678, 32'h0, 32'h0, 32'h0}, exp_count: 10'd13, exp_err: 1'b0};
    vecs[5] = '{len: 5'd31, zeros: 1'b1, w: '{32'h0, 32'h0, 32'h0, 32'h0}, exp_count: 10'd0, exp_err: 1'b1};
    vecs[6] = '{len: 5'd4,  zeros: 1'b1, w: '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, exp_count: 10'd0, exp_err: 1'b0};
    vecs[7] = '{len: 5'd1,  zeros: 1'b1, w: '{32'hAAAA_AAAA, 32'h0, 32'h0, 32'h0}, exp_count: 10'd16, exp_err: 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_zeros = 1'b0;
    data_valid = 1'b0; data_in = '0; res_ready = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_data_ready", 32'(data_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_count", 32'(res_count), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      send_cmd(vecs[v].len, vecs[v].zeros);
      if (vecs[v].len == 5'd0 || vecs[v].len > 5'd16) begin
        chk("direct_done_valid", 32'(res_valid), 32'd1);
        chk("direct_done_no_data_ready", 32'(data_ready), 32'd0);
      end else begin
        chk("accum_data_ready", 32'(data_ready), 32'd1);
        chk("accum_res_valid", 32'(res_valid), 32'd0);
        for (int k = 0; k < int'(vecs[v].len); k++)
          send_word(vecs[v].w[k], 0, k == int'(vecs[v].len) - 1);
      end
      get_result(0, vecs[v].exp_count, vecs[v].exp_err);
      $display("vec %0d: len=%0d zeros=%0d count=%0d err=%0d", v, vecs[v].len, vecs[v].zeros, res_count, res_err);
    end

    // Full burst with random gaps and a consumer that stalls for 5 cycles.
    send_cmd(5'd16, 1'b0);
    for (int k = 0; k < 16; k++)
      send_word(32'hFFFF_FFFF, int'($urandom_range(0, 3)), k == 15);
    get_result(5, 10'd512, 1'b0);
    $display("gap burst: len=16 count=%0d err=%0d", res_count, res_err);

    // Reset in the middle of a 4-word burst, with data still being offered.
    send_cmd(5'd4, 1'b0);
    send_word(32'hFFFF_FFFF, 0, 1'b0);
    send_word(32'hFFFF_FFFF, 0, 1'b0);
    data_valid = 1'b1;
    data_in    = 32'hFFFF_FFFF;
    rst_n      = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_res_count", 32'(res_count), 32'd0);
    chk("midrst_res_err", 32'(res_err), 32'd0);
    chk("midrst_data_ready", 32'(data_ready), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("midrst_data_ignored", 32'(data_ready), 32'd0);
    chk("midrst_still_idle", 32'(res_valid), 32'd0);
    data_valid = 1'b0;
    send_cmd(5'd1, 1'b0);
    send_word(32'h0000_0001, 0, 1'b1);
    get_result(0, 10'd1, 1'b0);
    $display("after reset: len=1 count=%0d err=%0d", res_count, res_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
